ladder_step_seq: RTL



---
 rtl/ladder_pkg.sv | 20 ++
 rtl/field_addsub.sv | 23 ++
 rtl/ladder_step_seq.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/ladder_pkg.sv
// Shared constants and enums for the sequenced Montgomery-ladder step.
// Defaults target Curve25519: P = 2^255-19, A24 = (486662+2)/4.
package ladder_pkg;

   localparam int            LADDER_W   = 256;
   localparam logic [255:0]  LADDER_P   = (256'd1 << 255) - 256'd19;
   localparam logic [255:0]  LADDER_A24 = 256'd121666;

   typedef enum logic [1:0] {IDLE, LOAD, RUN, FIN} state_e;

   typedef enum logic [3:0] {
      OP_AA, OP_BB, OP_DA, OP_CB, OP_X2N,
      OP_T, OP_X3N, OP_U, OP_Z3N, OP_Z2N
   } op_e;

   function automatic op_e next_op(input op_e op);
      return op_e'(op + 4'd1);
   endfunction

endpackage

// File: rtl/field_addsub.sv
// Combinational modular add and subtract of two field elements in [0, P).
module field_addsub
   import ladder_pkg::*;
#(
   parameter int           W = LADDER_W,
   parameter logic [W-1:0] P = W'(LADDER_P)
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum,
   output logic [W-1:0] diff
);

   logic [W:0] raw_sum;
   logic [W:0] red_sum;

   // The W+1-bit sum can exceed P once; a single conditional subtract reduces it.
   assign raw_sum = {1'b0, a} + {1'b0, b};
   assign red_sum = raw_sum - {1'b0, P};
   assign sum     = (raw_sum >= {1'b0, P}) ? red_sum[W-1:0] : raw_sum[W-1:0];
   assign diff    = (a >= b) ? (a - b) : (a - b + P);

endmodule

// File: rtl/ladder_step_seq.sv
// One Montgomery-ladder step (X-only) scheduled onto a shared external
// fixed-latency field multiplier; ops issue in order as soon as operands exist.
module ladder_step_seq
   import ladder_pkg::*;
#(
   parameter int           W       = LADDER_W,
   parameter logic [W-1:0] P       = W'(LADDER_P),
   parameter logic [W-1:0] A24     = W'(LADDER_A24),
   parameter int           MUL_LAT = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         swap,
   input  logic [W-1:0] x1,
   input  logic [W-1:0] x2,
   input  logic [W-1:0] z2,
   input  logic [W-1:0] x3,
   input  logic [W-1:0] z3,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] x2n,
   output logic [W-1:0] z2n,
   output logic [W-1:0] x3n,
   output logic [W-1:0] z3n,
   output logic         mul_valid,
   output logic [W-1:0] mul_a,
   output logic [W-1:0] mul_b,
   input  logic [W-1:0] mul_r
);

   state_e state, state_n;
   op_e    iss_op, ret_op;
   logic   iss_done;

   logic [W-1:0] x1_r, x2_r, z2_r, x3_r, z3_r;
   logic [W-1:0] a_r, b_r, c_r, d_r;
   logic [W-1:0] aa_r, bb_r, da_r, cb_r, t_r, e_r, u_r;
   logic [W-1:0] x2_t, x3_t, z3_t;
   logic [W-1:0] hold_a, hold_b;

   logic [W-1:0] as0_a, as0_b, as0_sum, as0_diff, as1_sum, as1_diff;
   logic         issue;
   logic [W-1:0] op_a, op_b;
   logic [MUL_LAT-1:0] vld_pipe;
   logic         arrive;

   // as0 is shared: (x2,z2) during LOAD, then whichever pair the pending op needs.
   field_addsub #(.W(W), .P(P)) u_as0 (
      .a(as0_a), .b(as0_b), .sum(as0_sum), .diff(as0_diff)
   );

   field_addsub #(.W(W), .P(P)) u_as1 (
      .a(x3_r), .b(z3_r), .sum(as1_sum), .diff(as1_diff)
   );

   assign arrive    = vld_pipe[MUL_LAT-1];
   assign mul_valid = issue;
   assign mul_a     = issue ? op_a : hold_a;
   assign mul_b     = issue ? op_b : hold_b;
   assign busy      = (state == LOAD) || (state == RUN);
   assign done      = (state == FIN);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      as0_a = x2_r;
      as0_b = z2_r;
      if (state == RUN) begin
         case (iss_op)
            OP_T:          begin as0_a = aa_r; as0_b = bb_r; end
            OP_X3N, OP_U:  begin as0_a = da_r; as0_b = cb_r; end
            OP_Z2N:        begin as0_a = bb_r; as0_b = t_r;  end
            default:       ;
         endcase
      end
   end

   // An op waits until every multiplier result it consumes has been captured
   // (ret_op has moved past it); op1 goes out in LOAD straight from the adder.
   always_comb begin
      state_n = state;
      issue   = 1'b0;
      op_a    = '0;
      op_b    = '0;
      unique case (state)
         IDLE: if (start) state_n = LOAD;
         LOAD: begin
            issue   = 1'b1;
            op_a    = as0_sum;
            op_b    = as0_sum;
            state_n = RUN;
         end
         RUN: begin
            if (!iss_done) begin
               case (iss_op)
                  OP_BB:  begin issue = 1'b1; op_a = b_r; op_b = b_r; end
                  OP_DA:  begin issue = 1'b1; op_a = d_r; op_b = a_r; end
                  OP_CB:  begin issue = 1'b1; op_a = c_r; op_b = b_r; end
                  OP_X2N: begin issue = (ret_op > OP_BB); op_a = aa_r; op_b = bb_r; end
                  OP_T:   begin issue = (ret_op > OP_BB); op_a = A24; op_b = as0_diff; end
                  OP_X3N: begin issue = (ret_op > OP_CB); op_a = as0_sum; op_b = as0_sum; end
                  OP_U:   begin issue = (ret_op > OP_CB); op_a = as0_diff; op_b = as0_diff; end
                  OP_Z3N: begin issue = (ret_op > OP_U); op_a = x1_r; op_b = u_r; end
                  OP_Z2N: begin issue = (ret_op > OP_T); op_a = e_r; op_b = as0_sum; end
                  default: ;
               endcase
            end
            if (arrive && (ret_op == OP_Z2N)) state_n = FIN;
         end
         FIN:     state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Results return in issue order, so ret_op alone identifies each arriving
   // product; outputs only change together when the last product lands.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe <= '0;
         iss_op   <= OP_AA;
         ret_op   <= OP_AA;
         iss_done <= 1'b0;
         hold_a   <= '0;
         hold_b   <= '0;
         x1_r <= '0; x2_r <= '0; z2_r <= '0; x3_r <= '0; z3_r <= '0;
         a_r  <= '0; b_r  <= '0; c_r  <= '0; d_r  <= '0;
         aa_r <= '0; bb_r <= '0; da_r <= '0; cb_r <= '0;
         t_r  <= '0; e_r  <= '0; u_r  <= '0;
         x2_t <= '0; x3_t <= '0; z3_t <= '0;
         x2n  <= '0; z2n  <= '0; x3n  <= '0; z3n  <= '0;
      end else begin
         vld_pipe[0] <= issue;
         for (int i = 1; i < MUL_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];

         if (state == IDLE && start) begin
            x1_r     <= x1;
            x2_r     <= swap ? x3 : x2;
            z2_r     <= swap ? z3 : z2;
            x3_r     <= swap ? x2 : x3;
            z3_r     <= swap ? z2 : z3;
            iss_op   <= OP_AA;
            ret_op   <= OP_AA;
            iss_done <= 1'b0;
         end

         if (state == LOAD) begin
            a_r <= as0_sum;
            b_r <= as0_diff;
            c_r <= as1_sum;
            d_r <= as1_diff;
         end

         if (issue) begin
            hold_a <= op_a;
            hold_b <= op_b;
            if (iss_op == OP_T) e_r <= as0_diff;
            if (iss_op == OP_Z2N) iss_done <= 1'b1;
            else                  iss_op   <= next_op(iss_op);
         end

         if (arrive) begin
            case (ret_op)
               OP_AA:  aa_r <= mul_r;
               OP_BB:  bb_r <= mul_r;
               OP_DA:  da_r <= mul_r;
               OP_CB:  cb_r <= mul_r;
               OP_X2N: x2_t <= mul_r;
               OP_T:   t_r  <= mul_r;
               OP_X3N: x3_t <= mul_r;
               OP_U:   u_r  <= mul_r;
               OP_Z3N: z3_t <= mul_r;
               OP_Z2N: begin
                  x2n <= x2_t;
                  x3n <= x3_t;
                  z3n <= z3_t;
                  z2n <= mul_r;
               end
               default: ;
            endcase
            if (ret_op != OP_Z2N) ret_op <= next_op(ret_op);
         end
      end
   end

endmodule
